mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It is the multi-cycle successor to the single-cycle MULT/MULTU/DIV/DIVU path in the ALU. The core issues an operation through a valid/ready handshake, stalls MFHI/MFLO on `busy`, and reads `hi`/`lo` directly. It also executes MTHI/MTLO.

---
 rtl/mips_muldiv_unit_if.sv | 38 +++
 rtl/mips_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if
//   Request/result bundle between a MIPS core and the iterative HI/LO
//   multiply/divide unit.
//
//   Handshake: the core raises op_valid with op_code/op_a/op_b stable and
//   holds all of them until an edge where op_valid && op_ready; that edge
//   is the accept. op_ready is high only while the unit is idle, and
//   op_valid seen while the unit is busy is simply ignored.
//
//   Ports (seen from the unit / slave side):
//     op_valid, op_code[2:0], op_a, op_b   in   request
//     op_ready                             out  unit idle
//     hi, lo                               out  architectural HI/LO
//     busy, done, div_zero                 out  status
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  op_ready, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output op_ready, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, plus MTHI/MTLO.
//   Multiply is shift-add (one multiplier bit per cycle), divide is
//   restoring (one quotient bit per cycle); both take WIDTH iteration
//   cycles followed by one FIX cycle that applies signs and writes HI/LO.
//
//   Ports:
//     clk           in   rising-edge clock
//     reset         in   synchronous, active-low
//     clock_enable  in   0 freezes all state (reset still acts)
//     bus           slave modport of mips_muldiv_unit_if
//     dbg_state     out  current FSM state (IDLE=0, MUL=1, DIV=2, FIX=3)
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clock_enable,
  mips_muldiv_unit_if.slave  bus,
  output logic [1:0]         dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_ZERO} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half shifts dividend bits out and quotient bits in.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               q_neg_q, q_neg_d;  // product / quotient sign
  logic               r_neg_q, r_neg_d;  // remainder sign (dividend sign)
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic               accept, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shifted, diff;

  always_comb begin
    accept    = bus.op_valid && (state_q == S_IDLE);
    is_signed = (bus.op_code == 3'b000) || (bus.op_code == 3'b010);
    a_neg     = is_signed && bus.op_a[WIDTH-1];
    b_neg     = is_signed && bus.op_b[WIDTH-1];
    // -x of the most-negative value is itself, which read unsigned is the
    // correct magnitude 2^(WIDTH-1).
    a_mag     = a_neg ? -bus.op_a : bus.op_a;
    b_mag     = b_neg ? -bus.op_b : bus.op_b;

    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {rem_q, prod_q[WIDTH-1]};
    // Top bit of diff is the borrow: set exactly when shifted < divisor.
    diff    = shifted - {1'b0, mcand_q};

    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    rem_d      = rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = (state_q == S_FIX);
    div_zero_d = (state_q == S_FIX) && (kind_q == K_ZERO);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            3'b000, 3'b001: begin
              state_d = S_MUL;
              kind_d  = K_MUL;
              cnt_d   = '0;
              prod_d  = {{WIDTH{1'b0}}, b_mag};
              mcand_d = a_mag;
              q_neg_d = a_neg ^ b_neg;
            end
            3'b010, 3'b011: begin
              if (bus.op_b == '0) begin
                state_d = S_FIX;
                kind_d  = K_ZERO;
              end else begin
                state_d = S_DIV;
                kind_d  = K_DIV;
                cnt_d   = '0;
                prod_d  = {{WIDTH{1'b0}}, a_mag};
                mcand_d = b_mag;
                rem_d   = '0;
                q_neg_d = a_neg ^ b_neg;
                r_neg_d = a_neg;
              end
            end
            3'b100:  hi_d = bus.op_a;
            3'b101:  lo_d = bus.op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d              = diff[WIDTH-1:0];
          prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d              = shifted[WIDTH-1:0];
          prod_d[WIDTH-1:0]  = {prod_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        case (kind_q)
          K_MUL:   {hi_d, lo_d} = q_neg_q ? -prod_q : prod_q;
          K_DIV: begin
            lo_d = q_neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
            hi_d = r_neg_q ? -rem_q : rem_q;
          end
          default: ;  // zero divisor: HI/LO keep their values
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      kind_q     <= K_MUL;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (clock_enable) begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      rem_q      <= rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
//   Directed bench for mips_muldiv_unit: a WIDTH=32 instance driven from a
//   vector table plus hand-written handshake / zero-divide / reset /
//   clock-enable sequences, and a WIDTH=8 instance checked against an
//   integer arithmetic model.
module tb_mips_muldiv_unit;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clock_enable = 1'b1;
  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(32)) bus32();
  mips_muldiv_unit_if #(.WIDTH(8))  bus8();
  logic [1:0] dbg32, dbg8;

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .clock_enable(clock_enable),
    .bus(bus32), .dbg_state(dbg32)
  );
  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .clock_enable(clock_enable),
    .bus(bus8), .dbg_state(dbg8)
  );

  int checks_total = 0;
  int checks_passed = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.op_code = op;
    bus32.op_a = a;
    bus32.op_b = b;
    bus32.op_valid = 1'b1;
    @(posedge clk); #1;
    bus32.op_valid = 1'b0;
  endtask

  task automatic wait_done32(output int lat);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus32.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.op_code = op;
    bus8.op_a = a;
    bus8.op_b = b;
    bus8.op_valid = 1'b1;
    @(posedge clk); #1;
    bus8.op_valid = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Reference arithmetic for the WIDTH=8 instance: {hi, lo}.
  function automatic logic [15:0] model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    logic [31:0] p, q, r;
    ia = op[0] ? int'(a) : int'($signed(a));
    ib = op[0] ? int'(b) : int'($signed(b));
    if (op[1] == 1'b0) begin
      p = ia * ib;
      return p[15:0];
    end else begin
      q = ia / ib;
      r = ia % ib;
      return {r[7:0], q[7:0]};
    end
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] a8, b8;
    logic [15:0] exp16;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[7]  = '{3'b011, 32'h00000007, 32'h00000009, 32'h00000007, 32'h00000000};
    vecs[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{3'b010, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2};

    bus32.op_valid = 1'b0; bus32.op_code = 3'b000; bus32.op_a = '0; bus32.op_b = '0;
    bus8.op_valid = 1'b0;  bus8.op_code = 3'b000;  bus8.op_a = '0;  bus8.op_b = '0;

    // ---------------- reset state ----------------
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus32.hi), 64'(0));
    check("rst_lo", 64'(bus32.lo), 64'(0));
    check("rst_busy", 64'(bus32.busy), 64'(0));
    check("rst_done", 64'(bus32.done), 64'(0));
    check("rst_div_zero", 64'(bus32.div_zero), 64'(0));
    check("rst_op_ready", 64'(bus32.op_ready), 64'(1));
    reset = 1'b1;

    // ---------------- vector table, issued back to back ----------------
    for (int i = 0; i < 12; i++) begin
      issue32(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_accept", i), 64'(bus32.busy), 64'(1));
      wait_done32(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(33));
      check($sformatf("v%0d_hi", i), 64'(bus32.hi), 64'(vecs[i].exp_hi));
      check($sformatf("v%0d_lo", i), 64'(bus32.lo), 64'(vecs[i].exp_lo));
      check($sformatf("v%0d_div_zero", i), 64'(bus32.div_zero), 64'(0));
      check($sformatf("v%0d_busy_at_done", i), 64'(bus32.busy), 64'(0));
    end

    // ---------------- handshake: op_valid held across a MULT ----------------
    bus32.op_code = 3'b000; bus32.op_a = 32'hFFFFFFFD; bus32.op_b = 32'd5;
    bus32.op_valid = 1'b1;
    @(posedge clk); #1;
    bus32.op_code = 3'b001; bus32.op_a = 32'd6; bus32.op_b = 32'd7;
    wait_done32(lat);
    check("hs_first_latency", 64'(lat), 64'(33));
    check("hs_first_hi", 64'(bus32.hi), 64'(32'hFFFFFFFF));
    check("hs_first_lo", 64'(bus32.lo), 64'(32'hFFFFFFF1));
    check("hs_ready_at_done", 64'(bus32.op_ready), 64'(1));
    @(posedge clk); #1;
    bus32.op_valid = 1'b0;
    check("hs_second_accepted", 64'(bus32.busy), 64'(1));
    wait_done32(lat);
    check("hs_second_latency", 64'(lat), 64'(33));
    check("hs_second_hi", 64'(bus32.hi), 64'(0));
    check("hs_second_lo", 64'(bus32.lo), 64'(42));

    // ---------------- no-op codes ----------------
    issue32(3'b110, 32'hDEADBEEF, 32'h1);
    check("nop110_hi", 64'(bus32.hi), 64'(0));
    check("nop110_lo", 64'(bus32.lo), 64'(42));
    check("nop110_busy", 64'(bus32.busy), 64'(0));
    issue32(3'b111, 32'hDEADBEEF, 32'h1);
    @(posedge clk); #1;
    check("nop111_lo", 64'(bus32.lo), 64'(42));
    check("nop111_done", 64'(bus32.done), 64'(0));

    // ---------------- MTHI/MTLO then divide by zero ----------------
    issue32(3'b100, 32'h12345678, 32'h0);
    check("mthi_hi", 64'(bus32.hi), 64'(32'h12345678));
    check("mthi_no_done", 64'(bus32.done), 64'(0));
    issue32(3'b101, 32'h9ABCDEF0, 32'h0);
    check("mtlo_lo", 64'(bus32.lo), 64'(32'h9ABCDEF0));
    check("mtlo_busy", 64'(bus32.busy), 64'(0));
    issue32(3'b011, 32'd5, 32'd0);
    @(posedge clk); #1;
    check("dz_done", 64'(bus32.done), 64'(1));
    check("dz_flag", 64'(bus32.div_zero), 64'(1));
    check("dz_hi_kept", 64'(bus32.hi), 64'(32'h12345678));
    check("dz_lo_kept", 64'(bus32.lo), 64'(32'h9ABCDEF0));
    @(posedge clk); #1;
    check("dz_done_clears", 64'(bus32.done), 64'(0));
    check("dz_flag_clears", 64'(bus32.div_zero), 64'(0));

    // ---------------- reset in the middle of a MULT ----------------
    issue32(3'b000, 32'h1234, 32'h5678);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_hi", 64'(bus32.hi), 64'(0));
    check("midrst_lo", 64'(bus32.lo), 64'(0));
    check("midrst_busy", 64'(bus32.busy), 64'(0));
    check("midrst_op_ready", 64'(bus32.op_ready), 64'(1));
    check("midrst_done", 64'(bus32.done), 64'(0));

    // ---------------- clock_enable low for 5 cycles mid-DIVU ----------------
    issue32(3'b011, 32'd1000, 32'd7);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      clock_enable = !(n >= 6 && n <= 10);
      @(posedge clk); #1;
      if (bus32.done) begin
        lat = n;
        break;
      end
    end
    clock_enable = 1'b1;
    check("ce_latency", 64'(lat), 64'(38));
    check("ce_lo", 64'(bus32.lo), 64'(142));
    check("ce_hi", 64'(bus32.hi), 64'(6));
    clock_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ce_done_stretch", 64'(bus32.done), 64'(1));
    clock_enable = 1'b1;
    @(posedge clk); #1;
    check("ce_done_drop", 64'(bus32.done), 64'(0));

    // ---------------- WIDTH=8 against the arithmetic model ----------------
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 40; i++) begin
        case (i)
          0:       begin a8 = 8'h80; b8 = 8'hFF; end
          1:       begin a8 = 8'hFF; b8 = 8'hFF; end
          2:       begin a8 = 8'h80; b8 = 8'h80; end
          3:       begin a8 = 8'h7F; b8 = 8'h01; end
          default: begin a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); end
        endcase
        if (op >= 2 && b8 == 8'h00) b8 = 8'h03;
        exp_q.push_back(model8(3'(op), a8, b8));
        issue8(3'(op), a8, b8);
        wait_done8(lat);
        if (i == 0) check($sformatf("w8_op%0d_latency", op), 64'(lat), 64'(9));
        exp16 = exp_q.pop_front();
        check($sformatf("w8_op%0d_a%0h_b%0h", op, a8, b8), 64'({bus8.hi, bus8.lo}), 64'(exp16));
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
